bin2bcd_seq: RTL and testbench

//  Sequential signed-binary to BCD converter on the calculator result path.

---
 rtl/bin2bcd_seq.sv | 62 ++++++
 tb/tb_bin2bcd_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: signed binary to sign + BCD digits, one double-dabble shift per clock
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter bit SIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] mag;
    logic [4*DIGITS-1:0] work, adj, shifted;
    logic sgn, in_sgn, last;
    always_comb begin
        in_sgn = SIGNED & bin_in[WIDTH-1];
        adj = work;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = work[4*i +: 4] >= 4'd5 ? work[4*i +: 4] + 4'd3 : work[4*i +: 4];
        shifted = (adj << 1) | {{(4*DIGITS-1){1'b0}}, mag[WIDTH-1]};
        last = state == SHIFT && cnt == LAST;
        state_nxt = state == IDLE  ? (start ? SHIFT : IDLE) :
                    state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    end
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_nxt;
    // bcd/neg are updated only on the final shift so the display never sees partial digits
    always_ff @(posedge clk)
        if (rst) begin
            cnt  <= '0;
            mag  <= '0;
            work <= '0;
            sgn  <= 1'b0;
            bcd  <= '0;
            neg  <= 1'b0;
        end else if (state == IDLE && start) begin
            sgn  <= in_sgn;
            mag  <= in_sgn ? -bin_in : bin_in;
            work <= '0;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            work <= shifted;
            mag  <= mag << 1;
            cnt  <= cnt + 1'b1;
            if (last) begin
                bcd <= shifted;
                neg <= sgn;
            end
        end
    assign busy = state == SHIFT;
    assign done = state == DONE;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: table and random vectors with a done-side scoreboard, plus abort/ignore sequences
module tb_bin2bcd_seq;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] bin_in = '0;
    logic busy, done, neg;
    logic [19:0] bcd;
    always #5 clk = ~clk;
    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .neg(neg), .bcd(bcd)
    );
    typedef struct {logic [15:0] bin; logic [19:0] bcd; logic neg;} vec_t;
    vec_t tbl[11];
    logic [20:0] q[$];
    logic [20:0] e;
    logic [19:0] held_bcd = '0;
    logic held_neg = 1'b0;
    int npass = 0, ntotal = 0, ndone = 0, npush = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    function automatic logic [20:0] model(input logic [15:0] v);
        int m;
        logic [19:0] r;
        m = v[15] ? 65536 - int'(v) : int'(v);
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {v[15], r};
    endfunction
    always @(negedge clk) begin
        if (done) begin
            ndone++;
            if (q.size() == 0) chk("spurious_done", ndone, npush);
            else begin
                e = q.pop_front();
                chk("bcd", {12'h0, bcd}, {12'h0, e[19:0]});
                chk("neg", {31'h0, neg}, {31'h0, e[20]});
            end
        end else if (busy)
            chk("hold_during_busy", {11'h0, neg, bcd}, {11'h0, held_neg, held_bcd});
        if (!busy) begin
            held_bcd = bcd;
            held_neg = neg;
        end
    end
    task automatic run(input logic [15:0] b, input logic [19:0] eb, input logic en);
        int lat = 0, nb = 0;
        @(negedge clk);
        bin_in = b;
        start = 1'b1;
        q.push_back({en, eb});
        npush++;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 40) begin
            if (busy) nb++;
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, 16);
        chk("busy_cycles", nb, 16);
        chk("busy_at_done", {31'h0, busy}, 32'h0);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        int lat;
        logic [15:0] v;
        tbl = '{
            '{16'h0000, 20'h00000, 1'b0}, '{16'h4000, 20'h16384, 1'b0},
            '{16'hFF85, 20'h00123, 1'b1}, '{16'h7FFF, 20'h32767, 1'b0},
            '{16'h8000, 20'h32768, 1'b1}, '{16'h0064, 20'h00100, 1'b0},
            '{16'h3039, 20'h12345, 1'b0}, '{16'hFFFF, 20'h00001, 1'b1},
            '{16'h0001, 20'h00001, 1'b0}, '{16'h270F, 20'h09999, 1'b0},
            '{16'hD8F1, 20'h09999, 1'b1}
        };
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_bcd", {12'h0, bcd}, 32'h0);
        chk("reset_neg", {31'h0, neg}, 32'h0);
        foreach (tbl[i]) run(tbl[i].bin, tbl[i].bcd, tbl[i].neg);
        for (int i = 0; i < 8; i++) begin
            v = 16'($urandom);
            e = model(v);
            run(v, e[19:0], e[20]);
        end
        // start mid-conversion and start during the done cycle must both be dropped
        @(negedge clk);
        bin_in = 16'h0064;
        start = 1'b1;
        q.push_back({1'b0, 20'h00100});
        npush++;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        bin_in = 16'h1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        chk("t5_done_seen", {31'h0, done}, 32'h1);
        bin_in = 16'h2222;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_done_pulse_width", {31'h0, done}, 32'h0);
        repeat (20) @(negedge clk);
        chk("t5_idle_after", {31'h0, busy}, 32'h0);
        // abort after 8 shifts, with a non-zero prior result on the outputs
        run(16'hFF85, 20'h00123, 1'b1);
        @(negedge clk);
        bin_in = 16'h3039;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        bin_in = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", {31'h0, busy}, 32'h0);
        chk("t6_done", {31'h0, done}, 32'h0);
        chk("t6_bcd", {12'h0, bcd}, 32'h0);
        chk("t6_neg", {31'h0, neg}, 32'h0);
        repeat (20) @(negedge clk);
        run(16'h3039, 20'h12345, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        bin_in = 16'h0005;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_beats_start", {31'h0, busy}, 32'h0);
        repeat (20) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        chk("done_count", ndone, npush);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
